loop_nest_controller: RTL
=========================

Name: loop_nest_controller

Overview:
- Sequences a two-level loop nest (outer × inner) for datapath blocks that iterate over tiles or rows.
- On a start pulse, latches the loop bounds and emits one (outer_idx, inner_idx) pair per accepted beat on a valid/ready stream.
- Flags the last beat, then pulses done.
- Sits between the control FSM and any address generator or compute unit that consumes index pairs.

Parameters:
- WIDTH, 8, width of each loop index and bound.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle request to begin a loop nest; honoured only in IDLE
- inner_max  input  WIDTH  last inner index (inclusive); sampled when start is accepted
- outer_max  input  WIDTH  last outer index (inclusive); sampled when start is accepted
- out_ready  input  1  consumer accepts the current index pair
- out_valid  output  1  index pair valid
- inner_idx  output  WIDTH  current inner index
- outer_idx  output  WIDTH  current outer index
- last_inner  output  1  inner_idx == latched inner_max (qualified by out_valid)
- last  output  1  final beat of the nest (qualified by out_valid)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- One clock domain, clk; rst is synchronous and active-high.
- Reset: state=IDLE; inner_idx=0, outer_idx=0; all 1-bit outputs 0; latched bounds=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches inner_max and outer_max, clears both indices, and moves to RUN.
  - out_valid rises the cycle after start: 1-cycle latency.
- RUN:
  - out_valid=1.
  - The indices and last flags hold stable while out_valid & !out_ready.
  - On a handshake (out_valid & out_ready):
    - If inner_idx != inner_max_q: inner_idx+1.
    - Else inner_idx=0. Then, if outer_idx != outer_max_q: outer_idx+1. Otherwise go to DONE.
  - last = (inner_idx==inner_max_q) & (outer_idx==outer_max_q).
- DONE: done=1, out_valid=0, busy=1 for exactly one cycle; then IDLE. Indices return to 0.
- Beat count: total beats = (inner_max+1)*(outer_max+1). Bounds of 0 give a single beat (last=1 on the first beat).
- Start outside IDLE (RUN or DONE) is ignored. No queuing.
- Bound inputs changing during RUN have no effect; only the latched copies are used.
- Arithmetic is unsigned WIDTH-bit. Indices never exceed the latched bounds, so no overflow is possible.
  - Bounds of 2^WIDTH-1 are legal and wrap to 0 via the equality compare.
- rst during RUN or DONE: immediate return to reset values next cycle. No done pulse.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro LOOP_NEST_ABORT_EN.
- With it: adds input abort (1 bit).
  - abort=1 in RUN goes to DONE on the next cycle regardless of out_ready; out_valid drops.
  - Adds output aborted (1 bit), asserted together with the done pulse.
  - A handshake in the same cycle as abort is still accepted by the consumer, but the controller does not advance past it.
  - abort in IDLE or DONE is ignored.
  - A simultaneous start and abort in IDLE behaves as start only.
- Without it: no abort or aborted ports; a nest always runs to completion.

Decomposition:
- Shared package loop_nest_pkg:
  - state typedef (IDLE, RUN, DONE).
  - State encoding constants.
- Natural sub-module: two instances of the team's circular_counter (inner, outer).
  - Enables are the handshake and the handshake & last_inner.
  - max is driven by the latched bound.
  - Their rst is driven by rst | start-accept | DONE.
- The FSM, bound latches and flags stay in loop_nest_controller.

Test Plan:
- WIDTH=8, inner_max=2, outer_max=1, out_ready held 1, start pulse -> 6 beats with (outer,inner) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). last_inner on beats 3 and 6; last on beat 6; done pulses one cycle later; busy spans start+1 through done.
- inner_max=0, outer_max=0 -> single beat with last=1 and last_inner=1, then done. Total busy time 2 cycles.
- out_ready toggling 1,0,0,1,... with bounds 3/0 -> indices and last hold stable while out_ready=0. Exactly 4 accepted beats, values 0..3.
- start re-pulsed mid-RUN, and inner_max/outer_max changed mid-RUN -> sequence unaffected; beat count equals the originally latched bounds.
- rst asserted during beat 2 of a 2/2 nest -> next cycle all outputs 0, state IDLE, no done pulse. A fresh start then runs the full 9 beats.
- With LOOP_NEST_ABORT_EN, abort during beat 3 of a 4/4 nest -> out_valid low the next cycle, done and aborted both 1 for one cycle, then IDLE.

Source files
------------

// File: rtl/loop_nest_pkg.sv
// Shared types for the two-level loop nest controller: FSM state encoding.
package loop_nest_pkg;

  localparam logic [1:0] StateIdleEnc = 2'b00;
  localparam logic [1:0] StateRunEnc  = 2'b01;
  localparam logic [1:0] StateDoneEnc = 2'b10;

  typedef enum logic [1:0] {
    StIdle = StateIdleEnc,
    StRun  = StateRunEnc,
    StDone = StateDoneEnc
  } state_e;

endpackage

// File: rtl/circular_counter.sv
// Counter that wraps to zero after reaching max_i; synchronous active-high reset.
module circular_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == max_i) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/loop_nest_controller.sv
// Emits (outer_idx, inner_idx) pairs over a valid/ready stream for a latched loop nest.
// Optional abort input/aborted output enabled by defining LOOP_NEST_ABORT_EN.
module loop_nest_controller
  import loop_nest_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] inner_max_i,
  input  logic [WIDTH-1:0] outer_max_i,
  input  logic             out_ready_i,
`ifdef LOOP_NEST_ABORT_EN
  input  logic             abort_i,
  output logic             aborted_o,
`endif
  output logic             out_valid_o,
  output logic [WIDTH-1:0] inner_idx_o,
  output logic [WIDTH-1:0] outer_idx_o,
  output logic             last_inner_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] inner_max_q, inner_max_d;
  logic [WIDTH-1:0] outer_max_q, outer_max_d;
  logic             abort;
  logic             handshake;
  logic             advance;
  logic             start_acc;
  logic             cnt_rst;

`ifdef LOOP_NEST_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort = abort_i & (state_q == StRun);
`else
  assign abort = 1'b0;
`endif

  assign start_acc = (state_q == StIdle) & start_i;
  assign handshake = out_valid_o & out_ready_i;
  // A beat accepted alongside abort is consumed but does not move the indices.
  assign advance   = handshake & ~abort;
  assign cnt_rst   = rst_i | start_acc | (state_q == StDone);

  circular_counter #(.WIDTH(WIDTH)) u_inner (
    .clk_i   (clk_i),
    .rst_i   (cnt_rst),
    .en_i    (advance),
    .max_i   (inner_max_q),
    .count_o (inner_idx_o)
  );

  circular_counter #(.WIDTH(WIDTH)) u_outer (
    .clk_i   (clk_i),
    .rst_i   (cnt_rst),
    .en_i    (advance & last_inner_o),
    .max_i   (outer_max_q),
    .count_o (outer_idx_o)
  );

  assign out_valid_o  = (state_q == StRun);
  assign last_inner_o = out_valid_o & (inner_idx_o == inner_max_q);
  assign last_o       = last_inner_o & (outer_idx_o == outer_max_q);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    inner_max_d = inner_max_q;
    outer_max_d = outer_max_q;
`ifdef LOOP_NEST_ABORT_EN
    aborted_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          inner_max_d = inner_max_i;
          outer_max_d = outer_max_i;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StDone;
`ifdef LOOP_NEST_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (handshake & last_o) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      inner_max_q <= '0;
      outer_max_q <= '0;
    end else begin
      state_q     <= state_d;
      inner_max_q <= inner_max_d;
      outer_max_q <= outer_max_d;
    end
  end

`ifdef LOOP_NEST_ABORT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted_o = done_o & aborted_q;
`endif

endmodule
